// File: rtl/stream_pkg.sv
// Shared constants for the stream sink and its LFSR: back-pressure mode codes,
// LFSR geometry and the Galois step function.
package stream_pkg;

  localparam logic [1:0] MODE_ALWAYS = 2'd0;
  localparam logic [1:0] MODE_PERIOD = 2'd1;
  localparam logic [1:0] MODE_RGAP   = 2'd2;
  localparam logic [1:0] MODE_RDUTY  = 2'd3;

  localparam int                LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Right-shifting Galois step: the bit shifted out selects whether the taps are applied.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] sh;
    sh = {1'b0, s[LFSR_W-1:1]};
    if (s[0]) begin
      lfsr_next = sh ^ LFSR_TAPS;
    end else begin
      lfsr_next = sh;
    end
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running 16-bit Galois LFSR, loaded with seed on reset and stepped every cycle.
module lfsr_gen
  import stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Next LFSR state.
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/stream_sink.sv
// Stream sink: selectable back-pressure on ready_out, registered capture of each
// accepted beat and per-packet length / count / XOR-checksum statistics.
module stream_sink
  import stream_pkg::*;
#(
  parameter int          DATA_W  = 8,
  parameter int          CNT_W   = 16,
  parameter int          GAP_W   = 3,
  parameter int          ON_CYC  = 2,
  parameter int          OFF_CYC = 1,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              last_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_vld,
  output logic              last_out,
  output logic              pkt_done,
  output logic [CNT_W-1:0]  pkt_len,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [DATA_W-1:0] pkt_xsum
);

  localparam int               PER     = ON_CYC + OFF_CYC;
  localparam int               PH_W    = $clog2(PER + 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PER - 1);
  localparam logic [PH_W-1:0]  PH_ON   = PH_W'(ON_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [LFSR_W-1:0] lfsr_s;
  logic              unused_lfsr_s;
  logic              accept_s;
  logic              mode_chg_s;
  logic [GAP_W-1:0]  gap_draw_s;
  logic [CNT_W-1:0]  len_inc_s;

  logic [1:0]        mode_q,     mode_d;
  logic [PH_W-1:0]   phase_q,    phase_d;
  logic [GAP_W-1:0]  gap_q,      gap_d;
  logic              ready_q,    ready_d;
  logic [DATA_W-1:0] data_q,     data_d;
  logic              vld_q,      vld_d;
  logic              last_q,     last_d;
  logic              done_q,     done_d;
  logic [CNT_W-1:0]  len_cnt_q,  len_cnt_d;
  logic [DATA_W-1:0] xsum_acc_q, xsum_acc_d;
  logic [CNT_W-1:0]  pkt_len_q,  pkt_len_d;
  logic [CNT_W-1:0]  pkt_cnt_q,  pkt_cnt_d;
  logic [DATA_W-1:0] pkt_xsum_q, pkt_xsum_d;

  lfsr_gen u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (SEED),
    .q     (lfsr_s)
  );

  assign unused_lfsr_s = ^lfsr_s;
  assign accept_s      = valid_in & ready_q;
  assign mode_chg_s    = (mode != mode_q);
  assign gap_draw_s    = lfsr_s[GAP_W-1:0];
  assign len_inc_s     = (len_cnt_q == CNT_MAX) ? CNT_MAX : len_cnt_q + 1'b1;

  // Back-pressure generator; a mode change restarts the phase/gap state.
  always_comb begin
    mode_d  = mode;
    phase_d = {PH_W{1'b0}};
    gap_d   = {GAP_W{1'b0}};
    ready_d = 1'b0;
    if (mode_chg_s) begin
      case (mode)
        MODE_RDUTY: ready_d = lfsr_s[0] | lfsr_s[1];
        default:    ready_d = 1'b1;  // period phase 0 is an ON cycle
      endcase
    end else begin
      case (mode_q)
        MODE_ALWAYS: ready_d = 1'b1;
        MODE_PERIOD: begin
          phase_d = (phase_q == PH_LAST) ? {PH_W{1'b0}} : phase_q + 1'b1;
          ready_d = (phase_d < PH_ON);
        end
        MODE_RGAP: begin
          // gap holds the low cycles still owed after the current one
          if (gap_q != {GAP_W{1'b0}}) begin
            gap_d   = gap_q - 1'b1;
            ready_d = 1'b0;
          end else if (accept_s && (gap_draw_s != {GAP_W{1'b0}})) begin
            gap_d   = gap_draw_s - 1'b1;
            ready_d = 1'b0;
          end else begin
            ready_d = 1'b1;
          end
        end
        MODE_RDUTY:  ready_d = lfsr_s[0] | lfsr_s[1];
        default:     ready_d = 1'b1;
      endcase
    end
  end

  // Beat capture and per-packet statistics.
  always_comb begin
    data_d     = data_q;
    last_d     = last_q;
    vld_d      = 1'b0;
    done_d     = 1'b0;
    len_cnt_d  = len_cnt_q;
    xsum_acc_d = xsum_acc_q;
    pkt_len_d  = pkt_len_q;
    pkt_cnt_d  = pkt_cnt_q;
    pkt_xsum_d = pkt_xsum_q;
    if (accept_s) begin
      data_d = data_in;
      last_d = last_in;
      vld_d  = 1'b1;
      if (last_in) begin
        pkt_len_d  = len_inc_s;
        pkt_xsum_d = xsum_acc_q ^ data_in;
        pkt_cnt_d  = pkt_cnt_q + 1'b1;
        done_d     = 1'b1;
        len_cnt_d  = {CNT_W{1'b0}};
        xsum_acc_d = {DATA_W{1'b0}};
      end else begin
        len_cnt_d  = len_inc_s;
        xsum_acc_d = xsum_acc_q ^ data_in;
      end
    end else begin
      vld_d = 1'b0;
    end
  end

  // Ready generator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_ALWAYS;
      phase_q <= {PH_W{1'b0}};
      gap_q   <= {GAP_W{1'b0}};
      ready_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
    end
  end

  // Capture and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= {DATA_W{1'b0}};
      last_q     <= 1'b0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      len_cnt_q  <= {CNT_W{1'b0}};
      xsum_acc_q <= {DATA_W{1'b0}};
      pkt_len_q  <= {CNT_W{1'b0}};
      pkt_cnt_q  <= {CNT_W{1'b0}};
      pkt_xsum_q <= {DATA_W{1'b0}};
    end else begin
      data_q     <= data_d;
      last_q     <= last_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      len_cnt_q  <= len_cnt_d;
      xsum_acc_q <= xsum_acc_d;
      pkt_len_q  <= pkt_len_d;
      pkt_cnt_q  <= pkt_cnt_d;
      pkt_xsum_q <= pkt_xsum_d;
    end
  end

  assign ready_out = ready_q;
  assign data_out  = data_q;
  assign data_vld  = vld_q;
  assign last_out  = last_q;
  assign pkt_done  = done_q;
  assign pkt_len   = pkt_len_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign pkt_xsum  = pkt_xsum_q;

endmodule

// File: tb/tb_stream_sink.sv
// Scoreboard bench for stream_sink: the driver queues expected beats/packets on each
// handshake, a negedge monitor pops and compares them whenever the DUT reports output.
module tb_stream_sink;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        last_in;
  logic        ready_out;
  logic [7:0]  data_out;
  logic        data_vld;
  logic        last_out;
  logic        pkt_done;
  logic [15:0] pkt_len;
  logic [15:0] pkt_cnt;
  logic [7:0]  pkt_xsum;

  stream_sink #(
    .DATA_W(8), .CNT_W(16), .GAP_W(3), .ON_CYC(2), .OFF_CYC(1), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .valid_in(valid_in), .data_in(data_in),
    .last_in(last_in), .ready_out(ready_out), .data_out(data_out), .data_vld(data_vld),
    .last_out(last_out), .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_cnt(pkt_cnt),
    .pkt_xsum(pkt_xsum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic last; logic [7:0] data; } beat_t;
  typedef struct packed { logic [15:0] len; logic [7:0] xsum; logic [15:0] cnt; } pkt_t;

  beat_t       beat_q[$];
  pkt_t        pkt_q[$];
  int          checks = 0;
  int          errors = 0;
  int          acc_len = 0;
  logic [7:0]  acc_x = 8'h00;
  int          exp_pkts = 0;
  logic [15:0] lfsr_m;
  logic [15:0] lfsr_prev;
  logic [7:0]  m0_data [4] = '{8'h11, 8'h22, 8'h44, 8'h88};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference LFSR, same reset/step timing as the DUT generator.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m    <= 16'hACE1;
      lfsr_prev <= 16'hACE1;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    end
  end

  // Monitor: pop expected beat/packet whenever the DUT presents one.
  always @(negedge clk) begin
    beat_t eb;
    pkt_t  ep;
    if (rst_n) begin
      if (data_vld || pkt_done)
        chk("pkt_done_align", 32'(pkt_done), 32'(data_vld & last_out));
      if (data_vld) begin
        if (beat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat", data_out);
        end else begin
          eb = beat_q.pop_front();
          chk("beat_data", 32'(data_out), 32'(eb.data));
          chk("beat_last", 32'(last_out), 32'(eb.last));
        end
      end
      if (pkt_done) begin
        if (pkt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pkt: got len %0d, expected no packet", pkt_len);
        end else begin
          ep = pkt_q.pop_front();
          chk("pkt_len", 32'(pkt_len), 32'(ep.len));
          chk("pkt_xsum", 32'(pkt_xsum), 32'(ep.xsum));
          chk("pkt_cnt", 32'(pkt_cnt), 32'(ep.cnt));
        end
      end
    end
  end

  // One cycle: at negedge optionally check ready, record a handshake, then resume at posedge+1.
  task automatic step(input logic en, input logic exp_rdy, input string nm, output logic hs);
    @(negedge clk);
    hs = valid_in & ready_out;
    if (en) chk(nm, 32'(ready_out), 32'(exp_rdy));
    if (hs) begin
      beat_q.push_back({last_in, data_in});
      if (last_in) begin
        exp_pkts++;
        pkt_q.push_back({16'(acc_len + 1), acc_x ^ data_in, 16'(exp_pkts)});
        acc_len = 0;
        acc_x   = 8'h00;
      end else begin
        acc_len++;
        acc_x = acc_x ^ data_in;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk("beats_drained_before_reset", 32'(beat_q.size()), 32'd0);
    chk("pkts_drained_before_reset", 32'(pkt_q.size()), 32'd0);
    rst_n = 1'b0;
    #2;
    chk("rst_ready_out", 32'(ready_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_data_vld", 32'(data_vld), 32'd0);
    chk("rst_last_out", 32'(last_out), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_pkt_len", 32'(pkt_len), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_pkt_xsum", 32'(pkt_xsum), 32'd0);
    acc_len  = 0;
    acc_x    = 8'h00;
    exp_pkts = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected simulation end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       hs;
    logic [2:0] g;
    int         gap;
    int         n;
    int         hi;
    int         acc_n;
    logic       found;

    rst_n = 1'b1; mode = 2'd0; valid_in = 1'b0; data_in = 8'h00; last_in = 1'b0;
    #1;
    do_reset();
    step(1'b1, 1'b0, "first_cycle_ready_low", hs);

    // Mode 0: 4-beat packet, one beat per cycle.
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = m0_data[i];
      last_in = (i == 3);
      step(1'b1, 1'b1, "m0_ready", hs);
      chk("m0_accept", 32'(hs), 32'd1);
    end
    valid_in = 1'b0; last_in = 1'b0;
    step(1'b0, 1'b0, "", hs);
    chk("m0_pkt_len", 32'(pkt_len), 32'd4);
    chk("m0_pkt_xsum", 32'(pkt_xsum), 32'hFF);
    chk("m0_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Mode 1: 9 cycles give pattern 1,1,0 and 6 accepts.
    mode = 2'd1;
    step(1'b0, 1'b0, "", hs);
    valid_in = 1'b1; last_in = 1'b1;
    acc_n = 0;
    for (int k = 0; k < 9; k++) begin
      data_in = 8'hA0 + 8'(k);
      step(1'b1, (k % 3) != 2, "m1_ready", hs);
      if (hs) acc_n++;
    end
    chk("m1_accepts", 32'(acc_n), 32'd6);

    // Single-beat packet in mode 0, then switch to mode 1 mid-stream.
    valid_in = 1'b0; mode = 2'd0;
    step(1'b0, 1'b0, "", hs);
    valid_in = 1'b1; data_in = 8'h5A; last_in = 1'b1;
    step(1'b1, 1'b1, "sb_ready", hs);
    valid_in = 1'b0;
    step(1'b0, 1'b0, "", hs);
    chk("sb_pkt_len", 32'(pkt_len), 32'd1);
    chk("sb_pkt_xsum", 32'(pkt_xsum), 32'h5A);
    valid_in = 1'b1; data_in = 8'h5B; mode = 2'd1;
    step(1'b1, 1'b1, "switch_cycle_ready", hs);
    for (int k = 0; k < 6; k++) begin
      data_in = 8'hC0 + 8'(k);
      step(1'b1, (k % 3) != 2, "switch_period_ready", hs);
    end

    // Mode 2: 20 beats in 5-beat packets; each accept owes lfsr[2:0] low cycles.
    valid_in = 1'b0; mode = 2'd2;
    step(1'b0, 1'b0, "", hs);
    gap = 0; n = 0;
    valid_in = 1'b1; data_in = 8'h30; last_in = 1'b0;
    for (int c = 0; c < 400 && n < 20; c++) begin
      g = lfsr_m[2:0];
      step(1'b1, gap == 0, "rgap_ready", hs);
      if (gap > 0) begin
        gap--;
      end else if (hs) begin
        gap = int'(g);
        n++;
        data_in = 8'h30 + 8'(n);
        last_in = ((n % 5) == 4);
      end
    end
    chk("rgap_beats", 32'(n), 32'd20);

    // Mode 3: ready follows lfsr[0]|lfsr[1] of the previous cycle.
    valid_in = 1'b0; mode = 2'd3;
    step(1'b0, 1'b0, "", hs);
    valid_in = 1'b1; last_in = 1'b1;
    hi = 0; acc_n = 0;
    for (int k = 0; k < 1000; k++) begin
      data_in = 8'(k);
      if (lfsr_prev[0] | lfsr_prev[1]) hi++;
      step(1'b1, lfsr_prev[0] | lfsr_prev[1], "rduty_ready", hs);
      if (hs) acc_n++;
    end
    chk("rduty_accepts", 32'(acc_n), 32'(hi));

    // Mode 2 again: find a gap of 2 or more and reset in its second low cycle.
    valid_in = 1'b0; mode = 2'd2;
    step(1'b0, 1'b0, "", hs);
    gap = 0; found = 1'b0;
    valid_in = 1'b1; data_in = 8'h70; last_in = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      g = lfsr_m[2:0];
      step(1'b1, gap == 0, "rgap2_ready", hs);
      if (gap > 0) begin
        gap--;
      end else if (hs) begin
        gap = int'(g);
        data_in = data_in + 8'h01;
        found = (g >= 3'd2);
      end
    end
    chk("rgap2_found_long_gap", 32'(found), 32'd1);
    valid_in = 1'b0;
    step(1'b1, 1'b0, "rgap2_in_gap", hs);
    mode = 2'd0;
    do_reset();
    step(1'b1, 1'b0, "rst2_first_cycle_ready_low", hs);

    // Two beats of a packet, then reset mid-packet.
    valid_in = 1'b1; last_in = 1'b0;
    data_in = 8'hF0;
    step(1'b1, 1'b1, "mp_ready", hs);
    data_in = 8'h0F;
    step(1'b1, 1'b1, "mp_ready", hs);
    valid_in = 1'b0;
    step(1'b0, 1'b0, "", hs);
    do_reset();
    step(1'b1, 1'b0, "rst3_first_cycle_ready_low", hs);

    // Fresh 3-beat packet after reset.
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'h01 << i;
      last_in = (i == 2);
      step(1'b1, 1'b1, "p3_ready", hs);
    end
    valid_in = 1'b0; last_in = 1'b0;
    step(1'b0, 1'b0, "", hs);
    chk("p3_pkt_len", 32'(pkt_len), 32'd3);
    chk("p3_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("p3_pkt_xsum", 32'(pkt_xsum), 32'h07);
    step(1'b0, 1'b0, "", hs);
    step(1'b0, 1'b0, "", hs);
    chk("beats_drained_at_end", 32'(beat_q.size()), 32'd0);
    chk("pkts_drained_at_end", 32'(pkt_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_sink.md
# stream_sink

Parametrised stream sink for testbench and bring-up use. It accepts a valid/ready/last stream and generates back-pressure in one of four selectable modes, including a deterministic LFSR-driven random mode. It registers each accepted beat and keeps per-packet statistics: beat count, packet count, last packet length and an XOR checksum. It sits at the tail of a stream datapath in place of a real consumer and exercises upstream handshake logic.

## Interface
- DATA_W, 8, data width
- CNT_W, 16, width of the beat-in-packet counter, packet counter and length outputs
- GAP_W, 3, width of the random gap field; gaps range 0..2^GAP_W-1
- ON_CYC, 2, ready-high cycles per period in mode 1 (≥1)
- OFF_CYC, 1, ready-low cycles per period in mode 1 (≥1)
- SEED, 16'hACE1, LFSR reset value; must be nonzero
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  back-pressure mode (0 always, 1 periodic, 2 random gap, 3 random duty)
- valid_in  in  1  upstream valid
- data_in  in  DATA_W  upstream data
- last_in  in  1  marks final beat of a packet
- ready_out  out  1  registered ready to upstream
- data_out  out  DATA_W  last accepted data
- data_vld  out  1  one-cycle pulse, data_out/last_out updated
- last_out  out  1  last_in of the accepted beat, qualified by data_vld
- pkt_done  out  1  one-cycle pulse after a last beat is accepted
- pkt_len  out  CNT_W  beat count of the most recent completed packet
- pkt_cnt  out  CNT_W  completed packets, wraps
- pkt_xsum  out  DATA_W  XOR of all beats of the most recent completed packet

## Operation
- Accept = valid_in & ready_out at a rising edge. Data is never taken when ready_out = 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Shifts every cycle out of reset, independent of mode. It is never zero.
- mode is registered into mode_q. When mode differs from mode_q, the phase and gap counters clear and ready_out is driven per the new mode from the next cycle.
- Mode 0: ready_out = 1 every cycle.
- Mode 1: free-running phase counter. ready_out is high for ON_CYC cycles, then low for OFF_CYC cycles, repeating. The pattern does not depend on accepts.
- Mode 2: ready_out is high until an accept occurs. At the accept edge, G = lfsr[GAP_W-1:0].
  - G > 0: ready_out is low for exactly G cycles, then high again.
  - G = 0: ready_out stays high.
- Mode 3: ready_out <= lfsr[0] | lfsr[1], giving about 75 % duty.
- Per-packet state: len_cnt and xsum_acc.
  - On a non-last accept: len_cnt += 1 (saturating at all-ones) and xsum_acc ^= data_in.
  - On a last accept: pkt_len <= len_cnt+1 (saturating), pkt_xsum <= xsum_acc ^ data_in, pkt_cnt += 1 (wrapping), pkt_done <= 1. len_cnt and xsum_acc then clear.
  - A single-beat packet (last on its first beat) gives pkt_len = 1 and pkt_xsum = data.
- Reset (asynchronous, any time, including mid-packet or mid-gap): every output is 0, LFSR = SEED, all counters and the accumulator clear, mode_q = 0. The partial packet is discarded.

## Timing
- ready_out is registered; no combinational path from valid_in to ready_out.
- Accept at edge t: data_out, last_out and data_vld are valid in cycle t+1. pkt_done and updated pkt_len/pkt_cnt/pkt_xsum also appear in t+1.
- First cycle after rst_n rises: ready_out = 0. The first rising edge then sets ready_out per mode (mode 0 and mode 2 go to 1).
- Back-to-back accepts:
  - Mode 0: one beat per cycle.
  - Mode 2 with G = 0: one beat per cycle.
  - Mode 1: ON_CYC beats per ON_CYC+OFF_CYC cycles.
- data_vld is low in every cycle without a preceding accept. data_out holds its last value.

## Structure
- Package stream_pkg:
  - mode localparams MODE_ALWAYS=0, MODE_PERIOD=1, MODE_RGAP=2, MODE_RDUTY=3
  - LFSR_W=16, LFSR_TAPS=16'hB400
- Sub-module lfsr_gen(clk, rst_n, seed, q): free-running Galois LFSR, reusable by the matching randomised source block.
- Remaining logic in stream_sink: ready generator and accept/statistics registers.

## Test plan
- Mode 0, 4-beat packet 8'h11, 8'h22, 8'h44, 8'h88 (last on the 4th), valid held high → ready_out always 1; 4 consecutive data_vld pulses; pkt_done one cycle after the 4th beat; pkt_len=4, pkt_xsum=8'hFF, pkt_cnt=1.
- Mode 1 (ON_CYC=2, OFF_CYC=1), valid always high, 9 cycles → ready_out pattern 1,1,0 repeating; exactly 6 accepts.
- Mode 2, SEED=16'hACE1, stream of 20 beats → after each accept, ready_out is low for exactly lfsr[2:0] cycles as computed by a bench LFSR model; no beat lost or duplicated.
- Mode 3, 1000 cycles, valid always high → ready_out matches the bench model (lfsr[0] | lfsr[1]) every cycle; accept count equals the count of high ready cycles.
- Single-beat packet 8'h5A with last in mode 0, then mode switched 0→1 mid-stream → pkt_len=1, pkt_xsum=8'h5A; the period-1 pattern starts from phase 0 on the cycle after the switch.
- rst_n pulled low mid-gap (mode 2) and mid-packet after 2 beats → all outputs 0 immediately; after release, next packet of 3 beats reports pkt_len=3, pkt_cnt=1.
